uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8, width of one UART character.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, mid-packet stall limit; used only under UART_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port s_tvalid  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port s_tdata  input  NUM_REQ*DATA_BITS  packed bytes; requester i at bits [i*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port s_tlast  input  NUM_REQ  per-requester end-of-packet.
REQ-009 SHALL have port s_tready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-010 SHALL have port tx_data  output  DATA_BITS  byte to the UART transmitter.
REQ-011 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port tx_done  input  1  one-cycle pulse from transmitter after stop bit.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  current owner index.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, SEND.
REQ-017 IDLE: when any s_tvalid is high, SHALL pick owner round-robin from rr_ptr upward (wrapping), register grant_id, go GRANT next cycle; no s_tready in IDLE.
REQ-018 GRANT: s_tready[grant_id] SHALL be combinationally equal to s_tvalid[grant_id]; all other s_tready bits low.
REQ-019 GRANT handshake (valid and ready): SHALL register tx_data, capture s_tlast as last_q, pulse tx_start in the next cycle, go SEND.
REQ-020 SEND: SHALL ignore all s_tvalid; on tx_done, last_q=1 -> IDLE with rr_ptr = grant_id+1 mod NUM_REQ; last_q=0 -> GRANT, same owner.
REQ-021 Ownership SHALL be held from first beat to tlast beat; other requesters wait regardless of priority.
REQ-022 Latency: s_tvalid rising in IDLE to s_tready = 1 cycle; handshake to tx_start = 1 cycle.
REQ-023 tx_done seen outside SEND SHALL be ignored; tx_start SHALL never pulse twice without an intervening tx_done.
REQ-024 Single requester active SHALL be granted immediately regardless of rr_ptr.
REQ-025 rr_ptr wrap: NUM_REQ-1 +1 SHALL yield 0.
REQ-026 tx_data SHALL hold its value until the next handshake.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, rr_ptr 0, grant_id 0, tx_data 0, tx_start 0, s_tready 0, busy 0, timeout_err 0, last_q 0, timeout counter 0.
REQ-028 Reset mid-packet SHALL drop the in-flight byte; no tx_start after release until a new handshake.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined: counter SHALL run in GRANT while s_tvalid[grant_id] low, clear on handshake; at TIMEOUT_CYCLES-1 go IDLE, advance rr_ptr, pulse timeout_err.
REQ-030 Without UART_ARB_TIMEOUT_EN: no counter in the netlist; timeout_err tied 0; GRANT waits indefinitely.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding and default DATA_BITS constant.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req vector, pointer in; one-hot grant and index out, combinational).

Verification
REQ-033 Req0 sends 3-byte packet 0x11,0x22,0x33 (tlast on 0x33), tx_done 10 cycles after each tx_start -> three tx_start pulses with those bytes, grant_id 0 throughout, then IDLE.
REQ-034 All four tvalid high from reset, 1-byte packets each -> grant order 0,1,2,3,0.
REQ-035 Req2 mid-packet, req1 asserts tvalid -> req1 not granted until req2 tlast accepted.
REQ-036 rst_n low 3 cycles during SEND after byte 0xA5 -> outputs zero, no tx_start after release, next byte from fresh handshake.
REQ-037 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req3 drops tvalid after non-last beat -> timeout_err pulse 16 cycles later, FSM IDLE, rr_ptr 0.
REQ-038 Spurious tx_done in IDLE and GRANT -> no state change, no extra tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default character width
// and the round-robin index wrap helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or above i_ptr (wrapping)
// wins, reported both one-hot and as an index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    int w_j;

    // Scan from farthest to nearest so the requester closest to i_ptr is written last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (i_req[IW'(w_j)]) begin
                o_gnt            = '0;
                o_gnt[IW'(w_j)]  = 1'b1;
                o_idx            = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART transmitter, one byte per tx_start/tx_done.
// Define UART_ARB_TIMEOUT_EN to release an owner that stalls mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DATA_BITS      = UART_DATA_BITS,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           s_tvalid,
    input  logic [NUM_REQ*DATA_BITS-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]           s_tlast,
    output logic [NUM_REQ-1:0]           s_tready,
    output logic [DATA_BITS-1:0]         tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic [IW-1:0]                grant_id,
    output logic                         busy,
    output logic                         timeout_err,
    output state_t                       o_dbg_state,
    output logic [IW-1:0]                o_dbg_rr_ptr
);

    // Handshake: a beat transfers on a rising clk edge where s_tvalid[i] && s_tready[i];
    // s_tready only ever follows the owner's s_tvalid while in GRANT.

    state_t                 r_state, w_state_nxt;
    logic [IW-1:0]          r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]          r_grant_id, w_grant_nxt;
    logic [DATA_BITS-1:0]   r_tx_data, w_data_nxt;
    logic                   r_last_q, w_last_nxt;
    logic                   r_tx_start, w_start_nxt;
    logic                   r_timeout_err, w_terr_nxt;
    logic [NUM_REQ-1:0]     w_arb_gnt;
    logic [IW-1:0]          w_arb_idx;
    logic [IW-1:0]          w_rr_inc;
    logic                   w_expire;
    logic [DATA_BITS-1:0]   w_bytes [NUM_REQ];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req (s_tvalid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) w_bytes[i] = s_tdata[i*DATA_BITS +: DATA_BITS];
    end

    assign w_rr_inc = IW'(wrap_inc(int'(r_grant_id), NUM_REQ));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    // Counts only idle GRANT cycles; any other state or a handshake restarts it.
    assign w_cnt_nxt = (r_state == ST_GRANT && !s_tvalid[r_grant_id] && !w_expire)
                       ? r_cnt + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= w_cnt_nxt;
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_data_nxt  = r_tx_data;
        w_last_nxt  = r_last_q;
        w_start_nxt = 1'b0;
        w_terr_nxt  = 1'b0;
        s_tready    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (|w_arb_gnt) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_tready[r_grant_id] = s_tvalid[r_grant_id];
                if (s_tvalid[r_grant_id]) begin
                    w_data_nxt  = w_bytes[r_grant_id];
                    w_last_nxt  = s_tlast[r_grant_id];
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (w_expire) begin
                    w_rr_nxt    = w_rr_inc;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (r_last_q) begin
                        w_rr_nxt    = w_rr_inc;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_GRANT;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_tx_data     <= '0;
            r_last_q      <= 1'b0;
            r_tx_start    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_grant_id    <= w_grant_nxt;
            r_tx_data     <= w_data_nxt;
            r_last_q      <= w_last_nxt;
            r_tx_start    <= w_start_nxt;
            r_timeout_err <= w_terr_nxt;
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != ST_IDLE);
    assign timeout_err  = r_timeout_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester source queues, a 10-cycle transmitter
// model and a scoreboard of expected {grant_id, byte} per tx_start.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ        = 4;
    localparam int DATA_BITS      = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int IW             = 2;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [NUM_REQ-1:0]           s_tvalid;
    logic [NUM_REQ*DATA_BITS-1:0] s_tdata;
    logic [NUM_REQ-1:0]           s_tlast;
    logic [NUM_REQ-1:0]           s_tready;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_start;
    logic                         tx_done;
    logic [IW-1:0]                grant_id;
    logic                         busy;
    logic                         timeout_err;
    state_t                       dbg_state;
    logic [IW-1:0]                dbg_rr_ptr;

    logic model_done = 1'b0;
    logic man_done   = 1'b0;
    assign tx_done = model_done | man_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_BITS      (DATA_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .o_dbg_state  (dbg_state),
        .o_dbg_rr_ptr (dbg_rr_ptr)
    );

    logic [9:0] exp_q [$];            // {grant_id, byte} expected at each tx_start
    logic [8:0] src_q [NUM_REQ][$];   // {tlast, byte} pending per requester
    int   n_checks = 0;
    int   n_errors = 0;
    logic terr_seen = 1'b0;
    logic start_pending = 1'b0;
    logic [DATA_BITS-1:0] last_byte = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] b, input logic last);
        src_q[id].push_back({last, b});
        exp_q.push_back({IW'(id), b});
    endtask

    function automatic logic src_empty();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && src_empty() && dbg_state == ST_IDLE) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    task automatic wait_grant_idle(input string tag, input int id, input int budget);
        int n = 0;
        while (!(dbg_state == ST_GRANT && exp_q.size() == 0 && src_q[id].size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_grant_wait"}, dbg_state, ST_GRANT);
    endtask

    // Requester driver: beats present from the queue head, popped after an accepted handshake.
    initial begin
        logic [NUM_REQ-1:0] hs;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*8 +: 8]    = src_q[i][0][7:0];
                    s_tlast[i]           = src_q[i][0][8];
                end else begin
                    s_tvalid[i]          = 1'b0;
                    s_tdata[i*8 +: 8]    = '0;
                    s_tlast[i]           = 1'b0;
                end
            end
        end
    end

    // Transmitter model: tx_done pulses 10 cycles after each tx_start.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (!rst_n) cnt = 0;
            else if (tx_start) cnt = 10;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_done = 1'b1;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                start_pending = 1'b0;
                last_byte     = '0;
            end else begin
                check("tready_onehot", 32'($countones(s_tready) <= 1), 1);
                if (timeout_err) terr_seen = 1'b1;
                if (tx_start) begin
                    check("start_pending", start_pending, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_start", tx_start, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx_data, e[7:0]);
                        check("grant_id", grant_id, e[9:8]);
                        last_byte = e[7:0];
                    end
                    start_pending = 1'b1;
                end else begin
                    check("tx_data_hold", tx_data, last_byte);
                end
                if (tx_done) start_pending = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_tready", s_tready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_rr_ptr", dbg_rr_ptr, 0);
        rst_n = 1'b1;
        tick();

        // Three-byte packet from requester 0.
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        drain("pkt3", 200);
        check("pkt3_rr", dbg_rr_ptr, 1);

        // All four requesters valid out of reset: order 0,1,2,3,0.
        rst_n = 1'b0;
        push(0, 8'h40, 1'b1);
        push(1, 8'h41, 1'b1);
        push(2, 8'h42, 1'b1);
        push(3, 8'h43, 1'b1);
        push(0, 8'h44, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        drain("rr4", 300);
        check("rr4_rr", dbg_rr_ptr, 1);

        // Requester 2 owns a packet; requester 1 arrives mid-packet and must wait.
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b0);
        push(2, 8'hC3, 1'b1);
        n = 0;
        while (!(busy && grant_id == 2) && n < 20) begin
            tick();
            n++;
        end
        check("hold_owner", grant_id, 2);
        push(1, 8'hD1, 1'b1);
        drain("hold", 300);
        check("hold_rr", dbg_rr_ptr, 2);

        // Reset during SEND of 0xA5 drops it; 0x5A comes from a fresh handshake.
        push(0, 8'hA5, 1'b0);
        push(0, 8'h5A, 1'b1);
        n = 0;
        while (dbg_state != ST_SEND && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("pre_rst_data", tx_data, 8'hA5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_rr", dbg_rr_ptr, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        drain("rst", 200);
        check("rst_rr_after", dbg_rr_ptr, 1);

        // Spurious tx_done in IDLE, then in GRANT between beats.
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        check("spur_idle_state", dbg_state, ST_IDLE);
        check("spur_idle_busy", busy, 0);
        push(0, 8'hE1, 1'b0);
        wait_grant_idle("spur", 0, 60);
        check("single_req_grant", grant_id, 0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("spur_grant_state", dbg_state, ST_GRANT);
        check("spur_grant_start", tx_start, 0);
`ifndef UART_ARB_TIMEOUT_EN
        repeat (40) tick();
        check("stall_state", dbg_state, ST_GRANT);
        check("stall_no_timeout", terr_seen, 0);
`endif
        push(0, 8'hE2, 1'b1);
        drain("spur", 200);
        check("spur_rr", dbg_rr_ptr, 1);

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 3 stalls after a non-last beat and is forcibly released.
        push(3, 8'hF1, 1'b0);
        wait_grant_idle("to", 3, 60);
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_state", dbg_state, ST_IDLE);
        check("timeout_rr", dbg_rr_ptr, 0);
        tick();
        check("timeout_pulse", timeout_err, 0);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
